// File: rtl/rgb_lookup_arbiter.sv
// Two-requester round-robin front end for a shared 8x24 colour BRAM.
// Define RGB_ARB_FIXED_PRIORITY_EN to make requester 0 win every contest.
module rgb_lookup_arbiter #(
   parameter int BRAM_LAT = 1,
   parameter int DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [2:0]  req0_colour,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [2:0]  req1_colour,
   output logic        req1_ready,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [23:0] resp_rgb,
   input  logic        resp_ready,
   output logic        bram_en,
   output logic [2:0]  bram_addr,
   input  logic [23:0] bram_dout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [CW-1:0]       r_count;
   logic [23:0]         r_mem_rgb [DEPTH];
   logic                r_mem_id  [DEPTH];
   logic [BRAM_LAT-1:0] r_pv;
   logic [BRAM_LAT-1:0] r_pid;
   logic [2:0]          r_addr;

   logic          w_any;
   logic          w_sel;
   logic          w_issue_ok;
   logic          w_go;
   logic          w_push;
   logic          w_push_id;
   logic          w_pop;
   logic [2:0]    w_colour;
   logic [CW-1:0] w_inflight;
   logic [CW:0]   w_credits;

   // Credits cover both FIFO entries and reads still inside the BRAM.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < BRAM_LAT; i++)
         w_inflight = w_inflight + CW'(r_pv[i]);
   end

   assign w_credits  = {1'b0, r_count} + {1'b0, w_inflight};
   assign w_issue_ok = w_credits < (CW+1)'(DEPTH);

`ifdef RGB_ARB_FIXED_PRIORITY_EN
   assign w_sel = ~req0_valid;
`else
   logic r_last;

   always_comb begin
      if (req0_valid && req1_valid)
         w_sel = ~r_last;
      else
         w_sel = ~req0_valid;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_last <= 1'b1;
      else if (w_go)
         r_last <= w_sel;
   end
`endif

   assign w_any      = req0_valid | req1_valid;
   assign w_go       = w_any & w_issue_ok & ~rst;
   assign w_colour   = w_sel ? req1_colour : req0_colour;
   assign req0_ready = w_go & ~w_sel;
   assign req1_ready = w_go & w_sel;
   assign bram_en    = w_go;
   assign bram_addr  = w_go ? w_colour : r_addr;

   always_ff @(posedge clk) begin
      if (rst)
         r_addr <= '0;
      else if (w_go)
         r_addr <= w_colour;
   end

   // Tag pipeline tracks each read through the BRAM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pv  <= '0;
         r_pid <= '0;
      end else begin
         r_pv[0]  <= w_go;
         r_pid[0] <= w_sel;
         for (int i = 1; i < BRAM_LAT; i++) begin
            r_pv[i]  <= r_pv[i-1];
            r_pid[i] <= r_pid[i-1];
         end
      end
   end

   assign w_push    = r_pv[BRAM_LAT-1];
   assign w_push_id = r_pid[BRAM_LAT-1];
   assign w_pop     = resp_valid & resp_ready;

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem_rgb[r_wptr] <= bram_dout;
         r_mem_id[r_wptr]  <= w_push_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign resp_valid = (r_count != '0);
   assign resp_rgb   = resp_valid ? r_mem_rgb[r_rptr] : 24'h0;
   assign resp_id    = resp_valid ? r_mem_id[r_rptr] : 1'b0;

endmodule

// File: doc/rgb_lookup_arbiter.md
# rgb_lookup_arbiter

Shares the single-port 8×24 colour-to-RGB block RAM between two requesters. Each requester presents a 3-bit colour code on a valid/ready handshake. The block arbitrates round-robin, issues one read per cycle to the BRAM, and tracks in-flight reads. It returns each RGB word, tagged with its requester ID, through a backpressured response FIFO. It sits between the colour-producing logic and the RAM; the RAM write port is tied off outside this block.

## Interface
- `BRAM_LAT`, 1, BRAM read latency in cycles from `bram_en` to `bram_dout` valid; legal values 1 or 2.
- `DEPTH`, 4, response FIFO depth and maximum outstanding reads; power of two, 2 to 16.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a lookup pending.
- `req0_colour` in 3: requester 0 colour code.
- `req0_ready` out 1: requester 0 lookup accepted this cycle.
- `req1_valid`, `req1_colour`, `req1_ready`: same as requester 0, for requester 1.
- `resp_valid` out 1: response FIFO head is valid.
- `resp_id` out 1: requester that issued the head entry.
- `resp_rgb` out 24: RGB word of the head entry.
- `resp_ready` in 1: consumer takes the head entry.
- `bram_en` out 1: BRAM read enable.
- `bram_addr` out 3: BRAM address.
- `bram_dout` in 24: BRAM read data.

## Operation
- **Credit counter.**
  - `credits_used` = FIFO occupancy + in-flight reads.
  - Issue is allowed when `credits_used < DEPTH`.
  - A pop frees its credit only from the next cycle. A same-cycle pop does not enable issue.
- **Arbitration.**
  - At most one grant per cycle, and only to a requester whose `valid` is high.
  - `reqN_ready` is combinational: it is high when requester N is granted and issue is allowed.
  - With both requesters valid, the grant goes to the requester not granted last.
  - The `last` pointer updates only on a grant.
  - Requesters hold `valid` and `colour` stable until `ready`. Dropping `valid` early is illegal.
- **Issue.** In the accept cycle:
  - `bram_en`=1 and `bram_addr`=granted colour.
  - A `BRAM_LAT`-deep shift register of {valid, id} enters the read.
- **Capture.** When the shift register's tail is valid, `bram_dout` is written into the FIFO with its id at that clock edge.
- **FIFO.**
  - Circular buffer with read/write pointers of width log2(`DEPTH`), wrapping at `DEPTH`-1 → 0.
  - Occupancy count ranges 0..`DEPTH`.
  - `resp_valid` = count≠0.
  - Pop occurs when `resp_valid` & `resp_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - The credit rule guarantees a push never meets a full FIFO.
- **Idle.** When no grant occurs, `bram_en`=0 and `bram_addr` holds its previous value.
- **Reset.** While `rst` is high at a clock edge:
  - FIFO is emptied, in-flight pipeline cleared, `last` set to 1 (so requester 0 wins the first contest).
  - In-flight reads are discarded; their data returning after reset is ignored.
  - While `rst` is high, `req0_ready`, `req1_ready` and `bram_en` are forced to 0.
- **Output reset values.** `resp_valid`=0, `resp_id`=0, `resp_rgb`=0, `bram_en`=0, `bram_addr`=0, `req0_ready`=0, `req1_ready`=0.

## Timing
- Request accepted at edge E (cycle t): the read is issued in cycle t.
- Data is captured at edge t+`BRAM_LAT`.
- `resp_valid` rises at cycle t+`BRAM_LAT`+1 when the FIFO was empty: 2 cycles for `BRAM_LAT`=1.
- Throughput is one lookup per cycle while credits allow. With `resp_ready` held high and `DEPTH`≥`BRAM_LAT`+2, throughput is sustained.
- Responses are returned in issue order. The FIFO is never reordered.
- `resp_rgb` and `resp_id` are stable while `resp_valid` is high and `resp_ready` is low.

## Configuration
- Macro `RGB_ARB_FIXED_PRIORITY_EN`.
  - Defined: requester 0 always wins when both are valid. The `last` pointer is unused and requester 1 can starve.
  - Undefined (default): round-robin as above.
- Handshake, latency and FIFO behaviour are identical in both builds.

## Test plan
ROM contents: 0→000000, 1→0000FF, 2→00FF00, 3→00FFFF, 4→FF0000, 5→FF00FF, 6→FFFF00, 7→FFFFFF.
- **Single lookup.** Reset, then requester 0 colour 4 with `resp_ready`=1 → `req0_ready` high the same cycle; two cycles later `resp_valid`=1, `resp_id`=0, `resp_rgb`=FF0000 for exactly one cycle.
- **Contention.** Both requesters valid every cycle with 0: colour 1 and 1: colour 6 → grants alternate 0,1,0,1, starting with 0. Responses alternate 0000FF/FFFF00 with ids 0,1,0,1. Under `RGB_ARB_FIXED_PRIORITY_EN`, every grant goes to 0.
- **Backpressure.** `resp_ready`=0, requester 1 streams colours 2,3,5,7,1 → exactly `DEPTH`=4 accepts, then `req1_ready`=0. FIFO holds 00FF00,00FFFF,FF00FF,FFFFFF. Raising `resp_ready` drains them in order. The fifth request (colour 1) is accepted no earlier than one cycle after the first pop and returns 0000FF.
- **Pointer wrap.** Issue 10 sequential lookups, colours 0..7 then 0,1, with `resp_ready` toggling every cycle → all 10 responses correct and in order, and no loss across the wrap of the FIFO pointer.
- **Reset mid-flight.** Accept colour 7, assert `rst` the next cycle → `resp_valid` stays 0 and the returning FFFFFF is discarded. The next post-reset request for colour 3 returns 00FFFF.
- **Latency 2.** `BRAM_LAT`=2, single colour 5 request → `resp_valid` three cycles after accept with FF00FF.
